// File: rtl/mux_arb_16_if.sv
// Bus bundle for the 16-way round-robin arbitrated mux: requests and packed
// channel data in, one granted channel out with valid/ready plus grant status.
interface mux_arb_16_if #(
  parameter int width  = 4,
  parameter int swidth = 4
) ();
  logic [15:0]         req;
  logic [16*width-1:0] din;
  logic                o_ready;
  logic                o_valid;
  logic [width-1:0]    o;
  logic [swidth-1:0]   sel;
  logic [15:0]         ack;
  logic                busy;

  modport master (
    output req, din, o_ready,
    input  o_valid, o, sel, ack, busy
  );

  modport slave (
    input  req, din, o_ready,
    output o_valid, o, sel, ack, busy
  );
endinterface

// File: rtl/mux_arb_16.sv
// Round-robin arbiter over 16 requesters that forwards the granted channel's
// data downstream under valid/ready and pulses a one-hot ack on completion.
module mux_arb_16 #(
  parameter int width  = 4,
  parameter int swidth = 4
) (
  input logic          clk,
  input logic          rst_n,
  mux_arb_16_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [swidth-1:0] sel_q, sel_d;
  logic [3:0]        last_q, last_d;
  logic [15:0]       ack_q, ack_d;

  // First set request searching upward from last+1; last itself ranks lowest.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] l);
    logic [3:0] pick;
    logic [3:0] idx;
    pick = l;
    for (int i = 16; i >= 1; i--) begin
      idx = l + 4'(i);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          sel_d   = swidth'(rr_pick(bus.req, last_q));
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.o_ready) begin
          ack_d   = 16'(1) << sel_q;
          last_d  = 4'(sel_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= 4'd15;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
    end
  end

  // Data path stays live in IDLE too: o shows the last granted channel.
  assign bus.o       = bus.din[sel_q*width +: width];
  assign bus.o_valid = (state_q == GRANT);
  assign bus.busy    = (state_q == GRANT);
  assign bus.sel     = sel_q;
  assign bus.ack     = ack_q;

endmodule

// File: tb/tb_mux_arb_16.sv
// Directed bench for mux_arb_16: stimulus queues expected transfers, a
// negedge monitor pops and compares them and checks the following ack pulse.
module tb_mux_arb_16;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] data;
  } xfer_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  xfer_t sb[$];

  // Channel k carries (k+7) mod 16.
  logic [3:0] rr_data [16] = '{4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE,
                               4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};

  mux_arb_16_if #(.width(4), .swidth(4)) bus ();

  mux_arb_16 #(.width(4), .swidth(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic [3:0] d);
    xfer_t e;
    e.sel  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  // Hold req for exactly n grants when o_ready stays high (2n-1 edges).
  task automatic burst(input logic [15:0] r, input int n);
    bus.req = r;
    repeat (2*n - 1) @(posedge clk);
    #1 bus.req = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: checks ack against the transfer seen one cycle earlier.
  initial begin
    logic [15:0] ack_exp;
    xfer_t e;
    ack_exp = '0;
    forever begin
      @(negedge clk);
      check("ack", 32'(bus.ack), 32'(ack_exp));
      ack_exp = '0;
      if (rst_n && bus.o_valid && bus.o_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer sel=%0d o=%0h expected=none at %0t",
                   bus.sel, bus.o, $time);
        end else begin
          e = sb.pop_front();
          check("xfer_sel", 32'(bus.sel), 32'(e.sel));
          check("xfer_o", 32'(bus.o), 32'(e.data));
          ack_exp = 16'(1) << e.sel;
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.o_ready = 1'b0;
    for (int k = 0; k < 16; k++) bus.din[k*4 +: 4] = rr_data[k];
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values hold through the cycle after release with req=0.
    @(negedge clk);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Single requester ch3.
    bus.o_ready = 1'b1;
    push(4'd3, 4'hA);
    burst(16'h0008, 1);
    drain();

    // Full round robin from reset: 0..15 then 0.
    apply_reset();
    for (int k = 0; k < 16; k++) push(4'(k), rr_data[k]);
    push(4'd0, 4'h7);
    burst(16'hFFFF, 17);
    drain();

    // Set last=14, then wrap and skip: 0, 4, 0.
    push(4'd14, 4'h5);
    burst(16'h4000, 1);
    drain();
    push(4'd0, 4'h7);
    push(4'd4, 4'hB);
    push(4'd0, 4'h7);
    burst(16'h0011, 3);
    drain();

    // Backpressure on ch5; data follows din while held.
    bus.o_ready = 1'b0;
    push(4'd5, 4'h3);
    bus.req = 16'h0020;
    @(posedge clk);
    #1 bus.req = '0;
    @(negedge clk);
    check("bp_o_before", 32'(bus.o), 32'hC);
    bus.din[5*4 +: 4] = 4'h3;
    #1 check("bp_o_follow", 32'(bus.o), 32'h3);
    repeat (5) begin
      @(negedge clk);
      check("bp_sel", 32'(bus.sel), 32'd5);
      check("bp_valid", 32'(bus.o_valid), 32'd1);
      check("bp_busy", 32'(bus.busy), 32'd1);
    end
    @(posedge clk);
    #1 bus.o_ready = 1'b1;
    drain();
    bus.din[5*4 +: 4] = 4'hC;

    // Request drop on ch7 while stalled still completes.
    bus.o_ready = 1'b0;
    push(4'd7, 4'hE);
    bus.req = 16'h0080;
    @(posedge clk);
    #1 bus.req = '0;
    repeat (2) begin
      @(negedge clk);
      check("drop_sel", 32'(bus.sel), 32'd7);
      check("drop_valid", 32'(bus.o_valid), 32'd1);
    end
    @(posedge clk);
    #1 bus.o_ready = 1'b1;
    drain();

    // Reset mid-grant of ch9 aborts without ack.
    bus.o_ready = 1'b0;
    bus.req = 16'h0200;
    @(posedge clk);
    #1 bus.req = '0;
    @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    check("mid_sel", 32'(bus.sel), 32'd9);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(bus.o_valid), 32'd0);
    check("abort_sel", 32'(bus.sel), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    bus.o_ready = 1'b1;
    push(4'd9, 4'h0);
    burst(16'h0200, 1);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
